// File: rtl/datablock_arbiter.sv
// Round-robin arbiter sharing the data block between two burst requesters.
// The winner gets a fixed-length read burst driven from a wrapping address
// counter. Hit returns are counted, and a one-cycle done pulse closes the burst.
module datablock_arbiter #(
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              CLK,
  input  logic              Rbar,
  input  logic              req0,
  input  logic [ADDR_W-1:0] start_addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] start_addr1,
  input  logic              status,
  output logic [ADDR_W-1:0] Da,
  output logic              rd_en,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [ADDR_W:0]   hit_cnt,
  output logic              busy
);

  // Beat and hit counters share a width. BURST_LEN <= 2^ADDR_W always fits.
  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   beat_q, beat_d;
  logic [CntW-1:0]   hit_q, hit_d;
  logic [ADDR_W-1:0] da_q, da_d;
  logic              last_q, last_d;  // last granted requester (1 = requester 1)
  logic              rd_en_q, rd_en_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              busy_q, busy_d;
  logic              pick1;

  // Requester 1 wins when it is alone, or on a tie when 0 was granted last.
  assign pick1 = req1 & (~req0 | ~last_q);

  // Next-state and registered-output logic for the three-state controller.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hit_d   = hit_q;
    da_d    = da_q;
    last_d  = last_q;
    rd_en_d = rd_en_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = done0_q;
    done1_d = done1_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d = StBurst;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          da_d    = pick1 ? start_addr1 : start_addr0;
          rd_en_d = 1'b1;
          beat_d  = '0;
          hit_d   = '0;
          last_d  = pick1;
          busy_d  = 1'b1;
        end
      end
      StBurst: begin
        hit_d = hit_q + CntW'(status);
        if (beat_q == LastBeat) begin
          // Da keeps the final beat address.
          rd_en_d = 1'b0;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          state_d = StDone;
        end else begin
          beat_d = beat_q + CntW'(1);
          da_d   = da_q + ADDR_W'(1);
        end
      end
      StDone: begin
        done0_d = 1'b0;
        done1_d = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; the pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK or negedge Rbar) begin
    if (!Rbar) begin
      state_q <= StIdle;
      beat_q  <= '0;
      hit_q   <= '0;
      da_q    <= '0;
      last_q  <= 1'b1;
      rd_en_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hit_q   <= hit_d;
      da_q    <= da_d;
      last_q  <= last_d;
      rd_en_q <= rd_en_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign Da      = da_q;
  assign rd_en   = rd_en_q;
  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign hit_cnt = hit_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_datablock_arbiter.sv
// Directed bench for datablock_arbiter. Expected beats and completions are queued
// when a request is driven; a negedge monitor pops and compares them as they appear.
module tb_datablock_arbiter;

  logic       CLK;
  logic       Rbar;
  logic       req0, req1, status;
  logic [1:0] start_addr0, start_addr1;
  logic [1:0] Da;
  logic       rd_en, gnt0, gnt1, done0, done1, busy;
  logic [2:0] hit_cnt;

  // Second instance with single-beat bursts.
  logic       b_req0, b_status;
  logic [1:0] b_start_addr0, b_Da;
  logic       b_rd_en, b_gnt0, b_gnt1, b_done0, b_done1, b_busy;
  logic [2:0] b_hit_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {logic id; logic [1:0] addr;} beat_t;
  typedef struct packed {logic id; logic [2:0] hits;} done_t;
  beat_t beat_q[$];
  done_t done_q[$];

  logic [3:0] stat_pat;
  logic [1:0] beat_idx;

  datablock_arbiter #(.ADDR_W(2), .BURST_LEN(4)) dut (
    .CLK(CLK), .Rbar(Rbar), .req0(req0), .start_addr0(start_addr0), .req1(req1),
    .start_addr1(start_addr1), .status(status), .Da(Da), .rd_en(rd_en), .gnt0(gnt0),
    .gnt1(gnt1), .done0(done0), .done1(done1), .hit_cnt(hit_cnt), .busy(busy)
  );

  datablock_arbiter #(.ADDR_W(2), .BURST_LEN(1)) dut_b (
    .CLK(CLK), .Rbar(Rbar), .req0(b_req0), .start_addr0(b_start_addr0), .req1(1'b0),
    .start_addr1(2'd0), .status(b_status), .Da(b_Da), .rd_en(b_rd_en), .gnt0(b_gnt0),
    .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1), .hit_cnt(b_hit_cnt), .busy(b_busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Beat position within the current burst, used to pick the status bit to return.
  always @(posedge CLK or negedge Rbar) begin
    if (!Rbar) beat_idx <= 2'd0;
    else if (rd_en) beat_idx <= beat_idx + 2'd1;
    else beat_idx <= 2'd0;
  end
  assign status = rd_en & stat_pat[beat_idx];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input logic id, input logic [1:0] addr, input int beats,
                            input logic [2:0] hits, input bit with_done);
    for (int i = 0; i < beats; i++) beat_q.push_back('{id: id, addr: addr + 2'(i)});
    if (with_done) done_q.push_back('{id: id, hits: hits});
  endtask

  task automatic wait_done(input logic id, input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(id ? done1 : done0) && n < 40);
    check(tag, id ? done1 : done0, 1);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor plus per-cycle invariants.
  always @(negedge CLK) begin
    beat_t b;
    done_t d;
    if (rd_en) begin
      if (beat_q.size() == 0) check("spurious_rd_en", rd_en, 0);
      else begin
        b = beat_q.pop_front();
        check("beat_da", Da, b.addr);
        check("beat_gnt", {gnt1, gnt0}, b.id ? 2'b10 : 2'b01);
      end
    end
    if (done0 | done1) begin
      if (done_q.size() == 0) check("spurious_done", done0 | done1, 0);
      else begin
        d = done_q.pop_front();
        check("done_who", {done1, done0}, d.id ? 2'b10 : 2'b01);
        check("done_gnt", {gnt1, gnt0}, d.id ? 2'b10 : 2'b01);
        check("done_hits", hit_cnt, d.hits);
        check("done_rd_en", rd_en, 0);
      end
    end
    check("gnt_exclusive", gnt0 & gnt1, 0);
    check("rd_en_busy", rd_en & ~busy, 0);
  end

  initial begin
    Rbar = 1'b1; req0 = 0; req1 = 0; start_addr0 = 0; start_addr1 = 0; stat_pat = 4'b0000;
    b_req0 = 0; b_start_addr0 = 0; b_status = 0;
    #1 Rbar = 1'b0;
    #1;
    // Reset state
    check("rst_da", Da, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_gnt", {gnt1, gnt0}, 0);
    check("rst_done", {done1, done0}, 0);
    check("rst_hit", hit_cnt, 0);
    check("rst_busy", busy, 0);
    repeat (2) step();
    Rbar = 1'b1;

    // Single request, all hits, wrapping addresses 2,3,0,1
    stat_pat = 4'b1111;
    push_burst(0, 2'd2, 4, 3'd4, 1);
    req0 = 1; start_addr0 = 2'd2;
    step();
    req0 = 0;
    check("t1_gnt0", gnt0, 1);
    wait_done(0, "t1_done0");
    step();
    check("t1_busy_fall", busy, 0);
    check("t1_done_pulse", done0, 0);
    check("t1_gnt_drop", gnt0, 0);
    check("t1_hit_hold", hit_cnt, 4);
    check("t1_da_hold", Da, 1);

    // Simultaneous requests after reset: 0, 1, 0
    Rbar = 1'b0;
    step();
    stat_pat = 4'b0101;
    push_burst(0, 2'd0, 4, 3'd2, 1);
    push_burst(1, 2'd1, 4, 3'd2, 1);
    push_burst(0, 2'd0, 4, 3'd2, 1);
    start_addr0 = 2'd0; start_addr1 = 2'd1; req0 = 1; req1 = 1;
    Rbar = 1'b1;
    wait_done(0, "t2_done0_a");
    step();
    check("t2_gap_rd_en", rd_en, 0);
    check("t2_gap_busy", busy, 0);
    step();
    check("t2_regrant1", {gnt1, gnt0}, 2'b10);
    wait_done(1, "t2_done1");
    wait_done(0, "t2_done0_b");
    step();
    req0 = 0; req1 = 0;

    // Status counting with pattern 1,0,1,1 from address 3
    step();
    stat_pat = 4'b1101;
    push_burst(1, 2'd3, 4, 3'd3, 1);
    req1 = 1; start_addr1 = 2'd3;
    step();
    req1 = 0;
    wait_done(1, "t3_done1");
    step();
    check("t3_hit_idle", hit_cnt, 3);
    repeat (3) step();
    check("t3_hit_hold", hit_cnt, 3);
    check("t3_da_hold", Da, 2);

    // One-cycle request pulse still gets the whole burst, and only one
    stat_pat = 4'b0000;
    push_burst(0, 2'd1, 4, 3'd0, 1);
    req0 = 1; start_addr0 = 2'd1;
    step();
    req0 = 0;
    check("t4_hit_clear", hit_cnt, 0);
    check("t4_da_start", Da, 1);
    wait_done(0, "t4_done0");
    repeat (8) step();
    check("t4_no_second", busy, 0);

    // Async reset during beat 2: only beats 0 and 1 are ever seen
    stat_pat = 4'b1111;
    push_burst(0, 2'd0, 2, 3'd0, 0);
    req0 = 1; start_addr0 = 2'd0;
    step();
    req0 = 0;
    step();
    step();
    Rbar = 1'b0;
    #1;
    check("t5_da", Da, 0);
    check("t5_rd_en", rd_en, 0);
    check("t5_gnt", {gnt1, gnt0}, 0);
    check("t5_done", {done1, done0}, 0);
    check("t5_hit", hit_cnt, 0);
    check("t5_busy", busy, 0);
    repeat (2) step();
    stat_pat = 4'b0000;
    push_burst(0, 2'd2, 4, 3'd0, 1);
    start_addr0 = 2'd2; start_addr1 = 2'd1; req0 = 1; req1 = 1;
    Rbar = 1'b1;
    step();
    check("t5_first_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 0; req1 = 0;
    wait_done(0, "t5_done0");
    repeat (2) step();

    // Single-beat instance
    b_req0 = 1; b_start_addr0 = 2'd1; b_status = 0;
    step();
    b_req0 = 0;
    check("b_rd_en", b_rd_en, 1);
    check("b_da", b_Da, 1);
    check("b_gnt0", b_gnt0, 1);
    step();
    check("b_rd_en_off", b_rd_en, 0);
    check("b_done0", b_done0, 1);
    check("b_hit", b_hit_cnt, 0);
    check("b_da_hold", b_Da, 1);
    step();
    check("b_done_pulse", b_done0, 0);
    check("b_busy", b_busy, 0);
    step();
    check("b_no_second", b_rd_en, 0);

    check("beats_drained", beat_q.size(), 0);
    check("dones_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/datablock_arbiter.md
Name: datablock_arbiter

Overview:
- Controller that shares the 2-bit-addressed data block between two requesters.
- Each requester asks for a burst of reads. The block arbitrates round-robin, then drives the data block address from an internal wrapping counter.
- During the burst it counts the data block's status (hit) returns and reports completion with a one-cycle done pulse.
- Sits between the requesters and the data block's address/status interface.

Parameters:
- ADDR_W, 2, width of data block address; the address counter wraps modulo 2^ADDR_W.
- BURST_LEN, 4, beats per burst; legal range 1..2^ADDR_W.

Ports:
- CLK  in  1  system clock, rising edge.
- Rbar  in  1  reset, asynchronous, active-low.
- req0  in  1  request from requester 0; level, sampled only in IDLE.
- start_addr0  in  ADDR_W  first burst address for requester 0.
- req1  in  1  request from requester 1.
- start_addr1  in  ADDR_W  first burst address for requester 1.
- status  in  1  hit flag from data block; valid in the same cycle as rd_en.
- Da  out  ADDR_W  address to data block.
- rd_en  out  1  read strobe, high for each burst beat.
- gnt0  out  1  requester 0 owns the data block.
- gnt1  out  1  requester 1 owns the data block.
- done0  out  1  one-cycle burst-complete pulse, requester 0.
- done1  out  1  one-cycle burst-complete pulse, requester 1.
- hit_cnt  out  ADDR_W+1  number of beats with status=1 in the current/last burst.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (Rbar=0, async):
  - Outputs: Da=0, rd_en=0, gnt0=gnt1=0, done0=done1=0, hit_cnt=0, busy=0.
  - Internal: state=IDLE, beat counter=0, last-granted pointer=1 (so requester 0 wins the first tie).
- States: IDLE, BURST, DONE, all registered; outputs are registered (no comb path from req to outputs).
- IDLE:
  - At a rising edge, if req0|req1, grant one requester.
    - Only one requesting: grant it.
    - Both requesting: grant the one not equal to last-granted.
  - At that edge:
    - state<=BURST; gnt_x<=1.
    - Da<=start_addr_x; rd_en<=1; beat<=0; hit_cnt<=0.
    - last-granted<=x; busy<=1.
- BURST:
  - Each edge while rd_en=1:
    - hit_cnt<=hit_cnt+status.
    - beat<=beat+1.
    - Da<=Da+1 mod 2^ADDR_W (wrap 3->0 for ADDR_W=2).
  - On the edge closing beat BURST_LEN-1: rd_en<=0, done_x<=1, state<=DONE. Da holds its last beat value.
- DONE (one cycle):
  - done_x=1, gnt_x=1, rd_en=0, hit_cnt final.
  - Next edge: done_x<=0, gnt_x<=0, busy<=0, state<=IDLE.
- Latency:
  - req sampled at edge k → rd_en/gnt high after k, beats at edges k+1..k+BURST_LEN.
  - done pulse during cycle after edge k+BURST_LEN.
  - IDLE after k+BURST_LEN+1.
  - The next grant occurs at the earliest at edge k+BURST_LEN+2, giving a minimum one-cycle IDLE gap between bursts.
- Held values: hit_cnt holds after DONE until the next grant clears it. Da holds its last value in IDLE.
- Requests outside IDLE: req changes during BURST/DONE are ignored. A burst is never aborted by the requester. The requester drops req when it sees done; a req still high in IDLE re-arbitrates normally.
- Fairness: with both req held continuously, grants alternate 0,1,0,1…
- Hit count range: hit_cnt never overflows; its maximum is BURST_LEN ≤ 2^ADDR_W, which fits in ADDR_W+1 bits.
- Reset mid-burst: everything clears immediately. No done pulse is issued, and the arbiter returns to IDLE with the pointer reset.
- Invariants:
  - gnt0 and gnt1 are never both 1.
  - done_x only occurs with gnt_x=1.
  - rd_en only occurs in BURST.

Test Plan:
- Reset then single request:
  - Stimulus: release Rbar, req0=1, start_addr0=2, status=1 on all beats.
  - Required: gnt0=1; Da sequence 2,3,0,1 with rd_en=1 for 4 cycles; done0 pulse for 1 cycle; hit_cnt=4; busy falls the cycle after done0.
- Simultaneous requests:
  - Stimulus: after reset, req0=req1=1 held, start_addr0=0, start_addr1=1.
  - Required: requester 0 served first (Da 0,1,2,3), then requester 1 (Da 1,2,3,0); a third burst goes to 0; gnt0 and gnt1 never overlap.
- Status counting:
  - Stimulus: req1, start_addr1=3, status pattern 1,0,1,1.
  - Required: Da 3,0,1,2; hit_cnt=3 during done1; hit_cnt holds at 3 in IDLE until the next grant.
- Request drop mid-burst:
  - Stimulus: req0 pulses high for one cycle only.
  - Required: the full 4-beat burst completes and done0 fires; no second burst.
- Async reset mid-burst:
  - Stimulus: Rbar=0 during beat 2.
  - Required: all outputs 0 immediately, with no done pulse. After Rbar=1 and req1=req0=1, requester 0 is granted first.
- BURST_LEN=1 instance:
  - Stimulus: req0, start_addr0=1, status=0.
  - Required: a single rd_en cycle with Da=1; done0 on the next cycle; hit_cnt=0.
